// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller
//
// Control FSM for a multicycle RV32I datapath. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK]. The controller
// issues memory handshakes, register-file/PC strobes and ALU controls. It
// counts retired instructions and drops into a sticky TRAP state on an
// illegal opcode, a memory timeout or (optionally) a misaligned access.
//
// Parameters
//   MEM_TIMEOUT    cycles a memory request may wait for mem_ready (1..255)
//   INSTRET_WIDTH  width of the retired-instruction counter
//
// Optional feature
//   MISALIGNED_TRAP_EN  when defined, misaligned lw/sw/lh/lhu/sh traps from
//                       EXECUTE with cause 11; otherwise addr_low is ignored.
//
// Ports
//   clock, reset_n       clock (rising edge) / async active-low reset
//   opcode, funct3,      instruction fields from the instruction register
//   funct7b5
//   zero                 ALU zero/compare flag used for branch resolution
//   addr_low             low bits of the ALU-computed data address
//   mem_ready            memory completes the current request
//   mem_req, mem_write   memory request / request is a store
//   memory_control       {store, funct3} access size/sign code
//   ir_write             latch fetched instruction
//   pc_write, PC_select  PC update strobe / 00 PC+4, 01 PC+imm, 10 rs1+imm
//   ALU_select           ALU operand B is the immediate
//   ALU_control          ALU operation
//   result_select        writeback source: 000 ALU, 001 memory, 010 PC+4
//   reg_write            register file write
//   trap, trap_cause     sticky fault / 01 illegal, 10 timeout, 11 misaligned
//   instret              retired instruction count
//   state                current FSM state encoding
// ============================================================================
module multicycle_controller #(
    parameter int MEM_TIMEOUT   = 15,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     zero,
    input  logic [1:0]               addr_low,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [3:0]               memory_control,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               PC_select,
    output logic                     ALU_select,
    output logic [3:0]               ALU_control,
    output logic [2:0]               result_select,
    output logic                     reg_write,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    // The wait counter times out on the cycle that would bring it to MEM_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [1:0]               cause_q, cause_d;
    logic [7:0]               wait_q, wait_d;
    logic [INSTRET_WIDTH-1:0] instret_q;

    // Instruction context captured in DECODE, used by later states.
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       funct7b5_q;

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_op, is_opimm, is_misc;
    logic illegal, taken, misaligned, wait_expired;
    logic [3:0] alu_op;

    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_jal    = (opcode_q == OP_JAL);
    assign is_jalr   = (opcode_q == OP_JALR);
    assign is_lui    = (opcode_q == OP_LUI);
    assign is_op     = (opcode_q == OP_OP);
    assign is_opimm  = (opcode_q == OP_IMM);
    assign is_misc   = (opcode_q == OP_FENCE) || (opcode_q == OP_SYSTEM);

    assign wait_expired = (wait_q == TIMEOUT_LAST) && !mem_ready;

`ifdef MISALIGNED_TRAP_EN
    assign misaligned = (is_load || is_store) &&
                        (((funct3_q[1:0] == 2'b10) && (addr_low != 2'b00)) ||
                         ((funct3_q[1:0] == 2'b01) && addr_low[0]));
`else
    logic unused_addr_low;
    assign unused_addr_low = ^addr_low;
    assign misaligned      = 1'b0;
`endif

    // Legality is judged on the live opcode while in DECODE.
    always_comb begin
        illegal = 1'b1;
        case (opcode)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: illegal = 1'b0;
            OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            default:   illegal = 1'b1;
        endcase
    end

    // The ALU compares with SUB/SLT/SLTU; zero=1 means equal / not-less.
    always_comb begin
        case (funct3_q)
            3'b000, 3'b101, 3'b111: taken = zero;
            3'b001, 3'b100, 3'b110: taken = ~zero;
            default:                taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (is_op) begin
            alu_op = {funct7b5_q, funct3_q};
        end else if (is_opimm) begin
            // Only the shift-right immediates carry funct7 bit 5 (srli/srai).
            alu_op = {(funct3_q == 3'b101) & funct7b5_q, funct3_q};
        end else if (is_branch) begin
            case (funct3_q[2:1])
                2'b10:   alu_op = ALU_SLT;
                2'b11:   alu_op = ALU_SLTU;
                default: alu_op = ALU_SUB;
            endcase
        end else if (is_lui) begin
            alu_op = ALU_PASSB;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cause_q   <= 2'b00;
            wait_q    <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            if (pc_write) begin
                instret_q <= instret_q + INSTRET_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == S_DECODE) begin
            opcode_q   <= opcode;
            funct3_q   <= funct3;
            funct7b5_q <= funct7b5;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_MEMORY;
                    end
                end else if (is_branch || is_misc) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WRITEBACK;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase

        // Counts only stalled request cycles within one state visit.
        wait_d = 8'd0;
        if (mem_req && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_req        = 1'b0;
        mem_write      = 1'b0;
        memory_control = 4'b0000;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        PC_select      = PC_SEQ;
        ALU_select     = 1'b0;
        ALU_control    = ALU_ADD;
        result_select  = 3'b000;
        reg_write      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Reset parks the FSM in FETCH; keep the request quiet until release.
                mem_req  = reset_n;
                ir_write = reset_n & mem_ready;
            end
            S_EXECUTE: begin
                ALU_select  = !(is_op || is_branch);
                ALU_control = alu_op;
                if (is_branch) begin
                    pc_write  = 1'b1;
                    PC_select = taken ? PC_IMM : PC_SEQ;
                end else if (is_misc) begin
                    pc_write = 1'b1;
                end
            end
            S_MEMORY: begin
                mem_req        = 1'b1;
                mem_write      = is_store;
                memory_control = {is_store, funct3_q};
                pc_write       = is_store & mem_ready;
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (is_load) begin
                    result_select = 3'b001;
                end else if (is_jal || is_jalr) begin
                    result_select = 3'b010;
                end
                if (is_jal) begin
                    PC_select = PC_IMM;
                end else if (is_jalr) begin
                    PC_select = PC_REG;
                end
            end
            default: ;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a memory request waits for mem_ready (range 1..255).
REQ-002 SHALL have parameter INSTRET_WIDTH, default 32, width of the retired-instruction counter.
REQ-003 SHALL have ports: clock  in  1  single clock, all state on rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: opcode  in  7  RV32I opcode; funct3  in  3  instruction funct3; funct7b5  in  1  funct7 bit 5; zero  in  1  ALU zero/compare flag.
REQ-005 SHALL have ports: addr_low  in  2  low bits of ALU-computed data address; mem_ready  in  1  memory completes current request.
REQ-006 SHALL have ports: mem_req  out  1  memory request; mem_write  out  1  request is a store; memory_control  out  4  access size/sign code (funct3-derived, bit3 = store).
REQ-007 SHALL have ports: ir_write  out  1  latch fetched instruction; pc_write  out  1  update PC; PC_select  out  2  00 PC+4, 01 PC+imm, 10 rs1+imm.
REQ-008 SHALL have ports: ALU_select  out  1  ALU operand B = immediate; ALU_control  out  4  ALU operation; result_select  out  3  writeback source; reg_write  out  1  register file write.
REQ-009 SHALL have ports: trap  out  1  sticky fault; trap_cause  out  2  01 illegal opcode, 10 memory timeout, 11 misaligned; instret  out  INSTRET_WIDTH  retired count; state  out  3  current FSM state.

Function
REQ-010 SHALL implement FSM states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; state output equals encoding.
REQ-011 SHALL sequence: ALU/LUI/AUIPC/JAL/JALR FETCH>DECODE>EXECUTE>WRITEBACK>FETCH; load adds MEMORY before WRITEBACK; store EXECUTE>MEMORY>FETCH; branch EXECUTE>FETCH.
REQ-012 SHALL in FETCH assert mem_req=1, mem_write=0 until mem_ready; ir_write=1 for exactly the cycle mem_ready=1, then go to DECODE.
REQ-013 SHALL in MEMORY assert mem_req=1, mem_write=1 for stores, memory_control from funct3; advance only on mem_ready.
REQ-014 SHALL assert pc_write for exactly one cycle per instruction, on its final state cycle; PC_select 01 for JAL and taken branch, 10 for JALR, else 00.
REQ-015 SHALL take branches: beq/bge/bgeu when zero=1; bne/blt/bltu when zero=0; funct3 010/011 with branch opcode is illegal.
REQ-016 SHALL assert reg_write only in WRITEBACK; ALU_control and ALU_select valid during EXECUTE; outputs are combinational from state and registered opcode context.
REQ-017 SHALL increment instret by 1 on every pc_write cycle, wrapping from all-ones to 0.
REQ-018 SHALL count consecutive cycles with mem_req=1 and mem_ready=0; counter clears on mem_ready and on state change.
REQ-019 SHALL enter TRAP with cause 10 when the wait count reaches MEM_TIMEOUT; mem_ready=1 on that same cycle wins (no trap).
REQ-020 SHALL enter TRAP from DECODE with cause 01 for any opcode outside the RV32I base set (excluding FENCE/SYSTEM, which retire as no-ops).
REQ-021 SHALL in TRAP hold trap=1, mem_req/pc_write/reg_write/ir_write=0, instret frozen, until reset; further inputs ignored.
REQ-022 SHALL ignore mem_ready when mem_req=0.

Reset
REQ-023 SHALL on reset_n=0 immediately force state=FETCH, trap=0, trap_cause=00, instret=0, wait counter=0; all strobes 0 while reset asserted.
REQ-024 SHALL abandon any in-flight request on reset mid-operation; first mem_req issued in the first cycle after reset_n deasserts.

Configuration
REQ-025 SHALL, with MISALIGNED_TRAP_EN defined, enter TRAP with cause 11 from EXECUTE when lw/sw has addr_low!=00 or lh/lhu/sh has addr_low[0]=1; no memory request issued.
REQ-026 SHALL, without MISALIGNED_TRAP_EN, ignore addr_low and never produce cause 11.

Verification
REQ-027 SHALL test: add (opcode 0110011) with mem_ready in first FETCH cycle -> 4-cycle instruction, reg_write in cycle 4, instret=1.
REQ-028 SHALL test: beq with zero=1 -> PC_select=01 with pc_write in EXECUTE; with zero=0 -> PC_select=00; 3 cycles each.
REQ-029 SHALL test: lw with mem_ready held low 15 cycles in MEMORY -> trap=1, cause=10, state=5; with ready at cycle 15 -> no trap.
REQ-030 SHALL test: opcode 0000000 -> TRAP cause 01 after DECODE; instret unchanged; reset_n pulse -> state=0, trap=0.
REQ-031 SHALL test: sw with addr_low=10 -> cause 11 when MISALIGNED_TRAP_EN defined, normal 4-cycle store otherwise.
REQ-032 SHALL test: INSTRET_WIDTH=4, 16 retired instructions -> instret wraps 15 to 0.
